// File: rtl/alu_exec_unit.sv
// Multi-cycle execution stage: single-cycle logic/arith ops and a 32-iteration
// shift-add multiplier behind a start/busy/done handshake.
module alu_exec_unit #(
  parameter bit MULT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  alu_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic        zero
);

  // state | meaning
  // IDLE  | waiting for start
  // EXEC  | single-cycle op on latched operands
  // MULT  | shift-add iterations, r_cnt counts down to 0
  // DONE  | result valid, done pulse; start accepted here too
  typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_a, r_b;
  logic [2:0]  r_op;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        w_accept;
  logic [31:0] w_res;
  logic [32:0] w_add33;
  logic [63:0] w_acc_nxt;

  assign busy     = (r_state == EXEC) || (r_state == MULT);
  assign done     = (r_state == DONE);
  assign w_accept = start && !busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start)
          w_state_nxt = (alu_op == 3'b111 && MULT_EN) ? MULT : EXEC;
        else
          w_state_nxt = IDLE;
      end
      EXEC:    w_state_nxt = DONE;
      MULT:    if (r_cnt == 6'd0) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_res = '0;
    case (r_op)
      3'b000:  w_res = r_a & r_b;
      3'b001:  w_res = r_a | r_b;
      3'b010:  w_res = ~(r_a | r_b);
      3'b011:  w_res = r_a ^ r_b;
      3'b100:  w_res = r_a + r_b;
      3'b101:  w_res = r_a - r_b;
      3'b110:  w_res = {31'b0, $signed(r_a) < $signed(r_b)};
      default: w_res = '0;  // op 111 without the multiplier
    endcase
  end

  // Multiplier sits in the low half and shifts out as the product shifts in.
  assign w_add33   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_acc_nxt = {w_add33, r_acc[31:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      out     <= '0;
      hi      <= '0;
      zero    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= in1;
        r_b   <= in2;
        r_op  <= alu_op;
        r_acc <= {32'b0, in2};
        r_cnt <= 6'd31;
      end
      case (r_state)
        EXEC: begin
          out  <= w_res;
          zero <= (w_res == 32'd0);
        end
        MULT: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd0) begin
            out  <= w_acc_nxt[31:0];
            hi   <= w_acc_nxt[63:32];
            zero <= (w_acc_nxt == 64'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random commands
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  alu_op;
  logic [31:0] in1, in2;
  logic        busy, done, zero;
  logic [31:0] out, hi;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;

  alu_exec_unit #(.MULT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .in1(in1), .in2(in2), .busy(busy), .done(done),
    .out(out), .hi(hi), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r_out, output logic r_zero, output int lat);
    logic [63:0] prod;
    lat = 2;
    case (op)
      3'd0: r_out = a & b;
      3'd1: r_out = a | b;
      3'd2: r_out = ~(a | b);
      3'd3: r_out = a ^ b;
      3'd4: r_out = a + b;
      3'd5: r_out = a - b;
      3'd6: r_out = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: begin
        prod   = 64'(a) * 64'(b);
        r_out  = prod[31:0];
        exp_hi = prod[63:32];
        lat    = 33;
      end
    endcase
    r_zero = (op == 3'd7) ? (prod == 64'd0) : (r_out == 32'd0);
  endtask

  // Issue one command (caller is in IDLE or DONE) and follow it to done.
  task automatic run_cmd(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_out;
    logic        e_zero;
    int          e_lat, n;
    model(op, a, b, e_out, e_zero, e_lat);
    alu_op = op; in1 = a; in2 = b; start = 1'b1;
    step();
    start = 1'b0;
    in1 = $urandom; in2 = $urandom; alu_op = 3'($urandom);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_lat"},  64'(n),    64'(e_lat));
    chk({tag, "_out"},  64'(out),  64'(e_out));
    chk({tag, "_zero"}, 64'(zero), 64'(e_zero));
    chk({tag, "_hi"},   64'(hi),   64'(exp_hi));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ndone;
    logic [2:0] rop;
    reset = 1'b1; start = 1'b0; alu_op = '0; in1 = '0; in2 = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out",  64'(out),  64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_zero", 64'(zero), 64'd0);

    run_cmd("nor",     3'd2, 32'hF0F0F0F0, 32'h0F0F0000);
    step();
    run_cmd("add_wrap", 3'd4, 32'hFFFFFFFF, 32'd1);
    run_cmd("sub_b2b",  3'd5, 32'd5, 32'd5);
    step();
    run_cmd("slt_neg",  3'd6, 32'hFFFFFFFF, 32'd1);
    run_cmd("slt_swap", 3'd6, 32'd1, 32'hFFFFFFFF);
    run_cmd("mult_max", 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_cmd("and_keep_hi", 3'd0, 32'h12345678, 32'h0F0F0F0F);
    chk("hi_after_and", 64'(hi), 64'h00000000FFFFFFFE);
    step();

    // Start while busy is dropped; exactly one done with the first result.
    alu_op = 3'd7; in1 = 32'd1000; in2 = 32'd77; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    alu_op = 3'd7; in1 = 32'hDEADBEEF; in2 = 32'h0BADF00D; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 6; i <= 40; i++) begin
      if (done) begin
        ndone++;
        chk("busy_start_cyc", 64'(i), 64'd33);
        chk("busy_start_out", 64'(out), 64'd77000);
        chk("busy_start_hi",  64'(hi),  64'd0);
      end
      step();
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    exp_hi = '0;

    // Reset mid-MULT.
    alu_op = 3'd7; in1 = 32'hFFFF0000; in2 = 32'h0000FFFF; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_out",  64'(out),  64'd0);
    chk("mrst_hi",   64'(hi),   64'd0);
    ndone = 0;
    for (int i = 11; i <= 40; i++) begin
      if (done) ndone++;
      step();
    end
    chk("mrst_ndone", 64'(ndone), 64'd0);
    exp_hi = '0;
    run_cmd("add_after_rst", 3'd4, 32'd2, 32'd3);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a, b;
      rop = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_cmd("rand", rop, a, b);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
